// File: rtl/pipo_ctrl_pkg.sv
// pipo_ctrl_pkg: shared state encoding, default sizes and width helper for the PIPO arbiter
package pipo_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_N_REQ = 4;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin priority encoder starting at a given index
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic [N-1:0]  win,
    output logic [IW-1:0] idx,
    output logic          any
);

    assign any = |req;

    // scan from farthest to nearest so the nearest set bit after start wins
    always_comb begin
        win = '0;
        idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(start) + k) % N]) begin
                win = '0;
                win[(int'(start) + k) % N] = 1'b1;
                idx = IW'((int'(start) + k) % N);
            end
        end
    end

endmodule

// File: rtl/pipo_rr_arbiter.sv
// pipo_rr_arbiter: round-robin arbitration of N_REQ writers onto one shared PIPO register
module pipo_rr_arbiter
    import pipo_ctrl_pkg::*;
#(
    parameter  int N_REQ       = DEF_N_REQ,
    parameter  int WIDTH       = DEF_WIDTH,
    parameter  int HOLD_CYCLES = 2,
    localparam int IW          = clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] din,
    output logic [N_REQ-1:0]       gnt,
    output logic                   ack,
    output logic [WIDTH-1:0]       out,
    output logic [IW-1:0]          owner,
    output logic                   valid
);

    state_t          state;
    logic [3:0]      cnt;
    logic [IW-1:0]   gidx;
    logic [IW-1:0]   start;
    logic [N_REQ-1:0] win;
    logic [IW-1:0]   widx;
    logic            any;
    logic            we;

    // the previous owner is searched last, giving it lowest priority
    assign start = (owner == IW'(N_REQ - 1)) ? '0 : owner + 1'b1;
    assign we    = (state == GRANT) && |(req & gnt);

    rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
        .req   (req),
        .start (start),
        .win   (win),
        .idx   (widx),
        .any   (any)
    );

    // shared holding register, loaded only by a committed grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            out <= '0;
        else if (we)
            out <= din[int'(gidx) * WIDTH +: WIDTH];
    end

    // arbitration FSM: pick in IDLE, commit or abort in GRANT, wait out HOLD
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            gnt   <= '0;
            ack   <= 1'b0;
            owner <= IW'(N_REQ - 1);
            valid <= 1'b0;
            cnt   <= '0;
            gidx  <= '0;
        end else begin
            ack <= 1'b0;
            case (state)
                IDLE: begin
                    gnt  <= win;
                    gidx <= widx;
                    if (any) state <= GRANT;
                end
                GRANT: begin
                    gnt   <= '0;
                    state <= IDLE;
                    if (we) begin
                        owner <= gidx;
                        valid <= 1'b1;
                        ack   <= 1'b1;
                        cnt   <= 4'(HOLD_CYCLES);
                        state <= (HOLD_CYCLES > 0) ? HOLD : IDLE;
                    end
                end
                HOLD: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == 4'd1) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pipo_rr_arbiter.sv
// tb_pipo_rr_arbiter: directed and random checks of two arbiter builds against a behavioural model
module tb_pipo_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [15:0] din = '0;

    logic [3:0] gnt0, gnt1;
    logic       ack0, ack1;
    logic [3:0] out0, out1;
    logic [1:0] owner0, owner1;
    logic       valid0, valid1;

    int n_checks = 0;
    int n_fail = 0;

    // model per build: pending grant index (-1 none), cycles left before arbitration
    int m_g[2];
    int m_wait[2];
    int m_owner[2];
    int m_out[2];
    int m_valid[2];
    int m_ack[2];

    pipo_rr_arbiter #(.N_REQ(4), .WIDTH(4), .HOLD_CYCLES(2)) u0 (
        .clk(clk), .rst_n(rst_n), .req(req), .din(din),
        .gnt(gnt0), .ack(ack0), .out(out0), .owner(owner0), .valid(valid0)
    );

    pipo_rr_arbiter #(.N_REQ(4), .WIDTH(4), .HOLD_CYCLES(0)) u1 (
        .clk(clk), .rst_n(rst_n), .req(req), .din(din),
        .gnt(gnt1), .ack(ack1), .out(out1), .owner(owner1), .valid(valid1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            m_g[u] = -1;
            m_wait[u] = 0;
            m_owner[u] = 3;
            m_out[u] = 0;
            m_valid[u] = 0;
            m_ack[u] = 0;
        end
    endtask

    // one clock edge of the spec: commit/abort a grant, count down the hold, or pick next requester
    task automatic model_step(input int u, input int h);
        bit found;
        m_ack[u] = 0;
        if (m_g[u] >= 0) begin
            if (req[m_g[u]]) begin
                m_out[u] = int'(din[m_g[u] * 4 +: 4]);
                m_owner[u] = m_g[u];
                m_valid[u] = 1;
                m_ack[u] = 1;
                m_wait[u] = h;
            end
            m_g[u] = -1;
        end else if (m_wait[u] > 0) begin
            m_wait[u]--;
        end else begin
            found = 0;
            for (int k = 1; k <= 4; k++) begin
                if (!found && req[(m_owner[u] + k) % 4]) begin
                    m_g[u] = (m_owner[u] + k) % 4;
                    found = 1;
                end
            end
        end
    endtask

    function automatic logic [3:0] m_gnt(input int u);
        return (m_g[u] >= 0) ? 4'(1 << m_g[u]) : 4'd0;
    endfunction

    task automatic check_all();
        check("u0.gnt", 32'(gnt0), 32'(m_gnt(0)));
        check("u0.ack", 32'(ack0), 32'(m_ack[0]));
        check("u0.out", 32'(out0), 32'(m_out[0]));
        check("u0.owner", 32'(owner0), 32'(m_owner[0]));
        check("u0.valid", 32'(valid0), 32'(m_valid[0]));
        check("u1.gnt", 32'(gnt1), 32'(m_gnt(1)));
        check("u1.ack", 32'(ack1), 32'(m_ack[1]));
        check("u1.out", 32'(out1), 32'(m_out[1]));
        check("u1.owner", 32'(owner1), 32'(m_owner[1]));
        check("u1.valid", 32'(valid1), 32'(m_valid[1]));
        check("u0.onehot", 32'($onehot0(gnt0)), 32'd1);
        check("u1.onehot", 32'($onehot0(gnt1)), 32'd1);
    endtask

    task automatic cyc();
        @(posedge clk);
        if (rst_n) begin
            model_step(0, 2);
            model_step(1, 0);
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic check_reset_vals();
        check("rst.gnt", 32'({gnt0, gnt1}), 32'd0);
        check("rst.ack", 32'({ack0, ack1}), 32'd0);
        check("rst.out", 32'({out0, out1}), 32'd0);
        check("rst.owner", 32'({owner0, owner1}), 32'h0f);
        check("rst.valid", 32'({valid0, valid1}), 32'd0);
    endtask

    initial begin
        model_reset();
        #12;
        check_reset_vals();
        @(negedge clk);
        rst_n = 1'b1;
        // first arbitration after reset favours requester 0
        req = 4'b1111;
        din = {4'b1000, 4'b0100, 4'b0010, 4'b0001};
        cyc();
        check("first_gnt", 32'(gnt0), 32'h1);
        for (int i = 0; i < 20; i++) cyc();
        // asynchronous reset while build 0 is holding
        for (int i = 0; i < 10 && !(m_wait[0] > 0 && m_g[0] < 0); i++) cyc();
        check("in_hold", 32'(m_wait[0] > 0), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_vals();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        // single write from requester 2
        req = 4'b0100;
        din = 16'h0a00;
        cyc();
        check("single_gnt", 32'(gnt0), 32'h4);
        req = 4'b0100;
        cyc();
        check("single_out", 32'(out0), 32'ha);
        req = 4'b0000;
        for (int i = 0; i < 4; i++) cyc();
        // abort: requester 1 drops its request in the grant cycle
        req = 4'b0010;
        din = 16'h00f0;
        cyc();
        req = 4'b0000;
        cyc();
        check("abort_ack", 32'(ack0), 32'd0);
        check("abort_out", 32'(out0), 32'ha);
        cyc();
        // late arrival: requester 1 raises during requester 0's hold
        for (int i = 0; i < 4; i++) cyc();
        req = 4'b0001;
        din = 16'h0005;
        cyc();
        cyc();
        req = 4'b0000;
        cyc();
        req = 4'b0010;
        begin
            bit seen;
            seen = 0;
            for (int i = 0; i < 10 && !seen; i++) begin
                cyc();
                seen = (gnt0 != 0);
            end
            check("late_seen", 32'(seen), 32'd1);
            check("late_gnt", 32'(gnt0), 32'h2);
        end
        // requesters 0 and 3 held: build 1 alternates every two cycles
        req = 4'b1001;
        din = 16'h7003;
        for (int i = 0; i < 12; i++) cyc();
        req = 4'b0000;
        for (int i = 0; i < 4; i++) cyc();
        // random requests and data
        for (int i = 0; i < 400; i++) begin
            req = 4'($urandom);
            din = 16'($urandom);
            cyc();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
